// File: rtl/branch_resolver.sv
// Branch resolver: queues fetch-time predictions in order and checks them against
// execute-stage outcomes, producing predictor updates, redirects and statistics.
module branch_resolver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic            f_pred_taken,
    input  logic [PC_W-1:0] f_pred_target,
    output logic            f_full,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            flush_in,
    output logic            upd_is_branch,
    output logic            upd_taken,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count,
    output logic            err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic            q_taken  [DEPTH];
    logic [PC_W-1:0] q_target [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            head_taken;
    logic [PC_W-1:0] head_target;
    logic            resolve;
    logic            mismatch;
    logic            push;
    logic            pop;
    logic            err_set;

    // The cycle after a redirect carries a wrong-path resolve, so mispredict gates execute.
    always_comb begin
        f_full      = (count == FULL_CNT);
        head_taken  = q_taken[rd_ptr];
        head_target = q_target[rd_ptr];
        resolve     = ex_valid && !flush_in && !mispredict && (count != '0);
        mismatch    = resolve && ((ex_taken != head_taken) ||
                                  (ex_taken && (ex_target != head_target)));
        push        = f_valid && !f_full && !flush_in && !mismatch;
        pop         = resolve && !mismatch;
        err_set     = ex_valid && !flush_in && !mispredict && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_taken[wr_ptr]  <= f_pred_taken;
            q_target[wr_ptr] <= f_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in || mismatch) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_is_branch <= 1'b0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            br_count      <= '0;
            mp_count      <= '0;
            err           <= 1'b0;
        end else begin
            upd_is_branch <= resolve;
            upd_taken     <= resolve ? ex_taken : 1'b0;
            mispredict    <= mismatch;
            if (mismatch)
                redirect_pc <= ex_taken ? ex_target : ex_pc + PC_W'(4);
            if (resolve && (br_count != '1))
                br_count <= br_count + 1'b1;
            if (mismatch && (mp_count != '1))
                mp_count <= mp_count + 1'b1;
            if (err_set)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a behavioural queue model predicts each
// update/redirect, which is queued at drive time and compared one cycle later.
module tb_branch_resolver;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            f_valid = 1'b0;
    logic            f_pred_taken = 1'b0;
    logic [PC_W-1:0] f_pred_target = '0;
    logic            f_full;
    logic            ex_valid = 1'b0;
    logic [PC_W-1:0] ex_pc = '0;
    logic            ex_taken = 1'b0;
    logic [PC_W-1:0] ex_target = '0;
    logic            flush_in = 1'b0;
    logic            upd_is_branch;
    logic            upd_taken;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;
    logic            err;

    branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
        .f_full(f_full),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .flush_in(flush_in),
        .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .mp_count(mp_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic t; logic [31:0] tg; } pred_t;
    typedef struct { logic t; logic mm; } exp_t;

    pred_t       mq[$];
    exp_t        sb[$];
    logic        m_mp = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_br = '0;
    logic [31:0] m_mpc = '0;
    logic [31:0] m_redir = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic cyc(input logic fv, input logic ft, input logic [31:0] ftg,
                       input logic ev, input logic [31:0] epc, input logic et,
                       input logic [31:0] etg, input logic fl);
        logic  full, mm;
        pred_t h;
        exp_t  e;
        f_valid = fv; f_pred_taken = ft; f_pred_target = ftg;
        ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg; flush_in = fl;
        mm = 1'b0;
        full = (mq.size() == DEPTH);
        if (fl) begin
            mq.delete();
        end else begin
            if (ev && !m_mp && mq.size() == 0) m_err = 1'b1;
            if (ev && !m_mp && mq.size() > 0) begin
                h = mq.pop_front();
                mm = (et != h.t) || (et && etg != h.tg);
                e.t = et; e.mm = mm;
                sb.push_back(e);
                if (m_br != '1) m_br++;
                if (mm) begin
                    if (m_mpc != '1) m_mpc++;
                    m_redir = et ? etg : epc + 32'd4;
                end
            end
            if (mm) mq.delete();
            else if (fv && !full) begin
                h.t = ft; h.tg = ftg;
                mq.push_back(h);
            end
        end
        m_mp = mm;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("upd_is_branch", upd_is_branch, 1);
            check("upd_taken", upd_taken, e.t);
            check("mispredict", mispredict, e.mm);
        end else begin
            check("upd_is_branch_idle", upd_is_branch, 0);
            check("mispredict_idle", mispredict, 0);
        end
        check("redirect_pc", redirect_pc, m_redir);
        check("f_full", f_full, mq.size() == DEPTH);
        check("err", err, m_err);
        check("br_count", br_count, m_br);
        check("mp_count", mp_count, m_mpc);
    endtask

    task automatic push(input logic t, input logic [31:0] tg);
        cyc(1'b1, t, tg, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        cyc(1'b0, 1'b0, '0, 1'b1, pc, t, tg, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        fv, ft, ev, et, fl;
        logic [31:0] ftg, etg, epc;

        #12;
        check("rst_upd", upd_is_branch, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_br", br_count, 0);
        check("rst_mp", mp_count, 0);
        check("rst_err", err, 0);
        check("rst_full", f_full, 0);
        rst = 1'b1;

        // Correct taken prediction.
        push(1'b1, 32'h100);
        resolve(32'hFC, 1'b1, 32'h100);
        check("basic_br_count", br_count, 1);
        idle(1);

        // Direction mispredict with younger entries, then a wrong-path resolve.
        push(1'b0, 32'h0);
        push(1'b1, 32'h10);
        push(1'b1, 32'h14);
        push(1'b1, 32'h18);
        resolve(32'h40, 1'b1, 32'h80);
        check("dir_redirect", redirect_pc, 32'h80);
        check("dir_mp_count", mp_count, 1);
        cyc(1'b1, 1'b1, 32'h500, 1'b1, 32'h44, 1'b1, 32'h500, 1'b0);
        for (int i = 0; i < 3; i++) push(1'b1, 32'h500);
        check("refill_full", f_full, 1);
        for (int i = 0; i < 4; i++) resolve(32'h60 + 32'(i * 4), 1'b1, 32'h500);

        // Not-taken fall-through and wrong-target redirects.
        push(1'b1, 32'h200);
        resolve(32'h1FC, 1'b0, 32'h0);
        check("nt_redirect", redirect_pc, 32'h200);
        idle(1);
        push(1'b1, 32'h300);
        resolve(32'h2FC, 1'b1, 32'h304);
        check("tgt_redirect", redirect_pc, 32'h304);
        idle(1);

        // Full, rejected push, pop+push while full, pointer wrap.
        for (int i = 0; i < 5; i++) push(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        check("full_pushpop", f_full, 0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h20 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) resolve(32'h80, 1'b0, 32'h0);
        check("wrap_no_err", err, 0);

        // Flush beats a same-cycle resolve and push; empty resolve sets err.
        push(1'b1, 32'h20);
        push(1'b1, 32'h24);
        cyc(1'b1, 1'b1, 32'h28, 1'b1, 32'h1C, 1'b1, 32'h20, 1'b1);
        resolve(32'h30, 1'b1, 32'h20);
        check("err_set", err, 1);
        idle(3);
        check("err_sticky", err, 1);

        for (int i = 0; i < 150; i++) begin
            fv  = 1'($urandom_range(0, 1));
            ft  = 1'($urandom_range(0, 1));
            ftg = $urandom_range(0, 1) ? 32'h100 : 32'h200;
            ev  = ($urandom_range(0, 2) == 0);
            epc = 32'($urandom_range(0, 255)) << 2;
            fl  = ($urandom_range(0, 24) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                et = mq[0].t; etg = mq[0].tg;
            end else begin
                et  = 1'($urandom_range(0, 1));
                etg = $urandom_range(0, 1) ? 32'h100 : 32'h300;
            end
            cyc(fv, ft, ftg, ev, epc, et, etg, fl);
        end
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        idle(1);

        // Mispredict counter saturation.
        force dut.mp_count = 32'hFFFF_FFFF;
        #1;
        release dut.mp_count;
        m_mpc = 32'hFFFF_FFFF;
        push(1'b0, 32'h0);
        resolve(32'h50, 1'b1, 32'h60);
        check("mp_saturate", mp_count, 32'hFFFF_FFFF);
        idle(1);

        // Asynchronous reset mid-cycle, then refill from empty.
        push(1'b1, 32'h700);
        resolve(32'h6FC, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_upd", upd_is_branch, 0);
        check("arst_upd_taken", upd_taken, 0);
        check("arst_mispredict", mispredict, 0);
        check("arst_redirect", redirect_pc, 0);
        check("arst_br", br_count, 0);
        check("arst_mp", mp_count, 0);
        check("arst_err", err, 0);
        check("arst_full", f_full, 0);
        mq.delete(); sb.delete();
        m_mp = 1'b0; m_err = 1'b0; m_br = '0; m_mpc = '0; m_redir = '0;
        #3;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 32'h700);
        check("post_rst_full", f_full, 1);
        for (int i = 0; i < 4; i++) resolve(32'h6FC, 1'b1, 32'h700);
        check("post_rst_br", br_count, 4);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of in-flight predicted-branch entries (power of two, 2..16).
REQ-002 The block SHALL have parameter PC_W, default 32, meaning the PC and target width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk (input, 1, clock) and rst (input, 1, reset, 0 = reset).
REQ-004 The block SHALL have port f_valid  input  1  fetch presents a branch instruction with its prediction this cycle.
REQ-005 The block SHALL have port f_pred_taken  input  1  predicted direction from the branch predictor.
REQ-006 The block SHALL have port f_pred_target  input  PC_W  predicted next PC when predicted taken.
REQ-007 The block SHALL have port f_full  output  1  queue full; fetch must hold the branch.
REQ-008 The block SHALL have port ex_valid  input  1  execute resolves the oldest branch this cycle.
REQ-009 The block SHALL have ports ex_pc  input  PC_W  branch PC; ex_taken  input  1  actual direction; ex_target  input  PC_W  actual taken target.
REQ-010 The block SHALL have port flush_in  input  1  external flush (exception/trap); discards all entries.
REQ-011 The block SHALL have outputs upd_is_branch  1  predictor update strobe, and upd_taken  1  actual direction, both feeding the predictor's training inputs.
REQ-012 The block SHALL have outputs mispredict  1  one-cycle redirect pulse, and redirect_pc  PC_W  correct next PC.
REQ-013 The block SHALL have outputs br_count  32  resolved-branch counter, mp_count  32  mispredict counter, and err  1  sticky protocol-error flag.

Function
REQ-014 The block SHALL hold an in-order circular queue of {pred_taken, pred_target}, with a write pointer, a read pointer and an occupancy count of 0..DEPTH.
REQ-015 The block SHALL assert f_full combinationally while count == DEPTH; a push occurs only when f_valid && !f_full.
REQ-016 When ex_valid and count > 0, the block SHALL pop the head and compare: mismatch = (ex_taken != pred_taken) || (ex_taken && ex_target != pred_target).
REQ-017 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 A pop while full SHALL NOT admit a same-cycle push, because f_full is computed from the pre-edge count.
REQ-019 One cycle after a valid resolve, the block SHALL assert upd_is_branch = 1 and upd_taken = ex_taken, registered, for exactly one cycle per resolve.
REQ-020 On mismatch, the block SHALL pulse mispredict for one cycle (registered, same cycle as upd_is_branch) and SHALL set redirect_pc = ex_taken ? ex_target : ex_pc + 4, with the addition truncated to PC_W.
REQ-021 redirect_pc SHALL hold its last value when mispredict is 0.
REQ-022 On mismatch, all entries younger than the resolved one SHALL be discarded at the same edge (count := 0, rd_ptr := wr_ptr), and a push in that cycle SHALL be dropped.
REQ-023 While mispredict is high, the block SHALL ignore ex_valid; a resolve in that cycle SHALL be treated as a wrong-path instruction, with no pop, no update and no counter change.
REQ-024 On flush_in, the queue SHALL be cleared and any same-cycle push or resolve ignored, with no mispredict and no update; flush_in takes priority over mismatch.
REQ-025 When ex_valid is asserted with count == 0 (and no flush/mispredict), the block SHALL set err and leave it set until reset, with no other effect.
REQ-026 br_count SHALL increment on each accepted resolve and mp_count on each mismatch; both SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-027 While rst = 0, the block SHALL asynchronously force the following: count, pointers, br_count and mp_count = 0; upd_is_branch, upd_taken, mispredict and err = 0; redirect_pc = 0; f_full = 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first push SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-029 Push 1 entry {taken = 1, target = 0x100}, then resolve ex_taken = 1, ex_target = 0x100 -> next cycle upd_is_branch = 1, upd_taken = 1, mispredict = 0, br_count = 1.
REQ-030 Push {pred_taken = 0}, then resolve ex_pc = 0x40, ex_taken = 1, ex_target = 0x80 -> mispredict = 1, redirect_pc = 0x80, mp_count = 1; with 3 younger entries queued, count = 0 afterwards.
REQ-031 Push {taken = 1, target = 0x200}, then resolve ex_pc = 0x1FC, ex_taken = 0 -> mispredict = 1, redirect_pc = 0x200 (pc + 4); push {taken = 1, target = 0x300}, then resolve taken with target 0x304 -> mispredict, redirect_pc = 0x304.
REQ-032 Push 4 entries -> f_full = 1, a 5th push is rejected; push + pop in the same cycle while full -> count = 3; wrap pointers through 10 push/pop pairs with no error.
REQ-033 With 2 entries queued, assert flush_in together with a resolve and a push -> count = 0, no update, no mispredict; a subsequent resolve with count 0 -> err = 1 and stays 1.
REQ-034 Preset mp_count to 0xFFFF_FFFF and force a mismatch -> mp_count stays 0xFFFF_FFFF; drop rst to 0 asynchronously mid-cycle -> all outputs are 0 immediately.
